// File: rtl/alu_array_pkg.sv
// Shared opcode encoding and slice helpers for the multi-channel ALU array.
package alu_array_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_ACC = 3'd7
    } op_e;

    function automatic int unsigned sliceLo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/alu_lane.sv
// One ALU channel: opcode decode, optional saturation, carry/borrow and its private accumulator.
module alu_lane
    import alu_array_pkg::*;
#(
    parameter int W   = 4,
    parameter bit SAT = 1'b0
) (
    input  logic           clock_i,
    input  logic           resetb_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [OPW-1:0] op_i,
    input  logic           accClr_i,
    input  logic           load_i,
    output logic [W:0]     res_o,
    output logic           carry_o
);

    logic [W:0]   sumAB;
    logic [W:0]   diffAB;
    logic [W:0]   accSum;
    logic [W-1:0] accBase;
    logic [W-1:0] accNext;
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        sumAB   = {1'b0, a_i} + {1'b0, b_i};
        diffAB  = {1'b0, a_i} - {1'b0, b_i};
        accBase = accClr_i ? '0 : acc_q;
        accSum  = {1'b0, accBase} + {1'b0, a_i};
        res_o   = '0;
        carry_o = 1'b0;
        accNext = accClr_i ? '0 : acc_q;
        case (op_e'(op_i))
            OP_ADD: begin
                carry_o = sumAB[W];
                res_o   = {sumAB[W], (SAT && sumAB[W]) ? {W{1'b1}} : sumAB[W-1:0]};
            end
            // The top bit of the widened difference is exactly the a<b borrow.
            OP_SUB: begin
                carry_o = diffAB[W];
                res_o   = {diffAB[W], (SAT && diffAB[W]) ? {W{1'b0}} : diffAB[W-1:0]};
            end
            OP_AND: res_o = {1'b0, a_i & b_i};
            OP_OR:  res_o = {1'b0, a_i | b_i};
            OP_XOR: res_o = {1'b0, a_i ^ b_i};
            OP_NOT: res_o = {1'b0, ~a_i};
            OP_SHL: res_o = {a_i, 1'b0};
            OP_ACC: begin
                carry_o = accSum[W];
                res_o   = {accSum[W], (SAT && accSum[W]) ? {W{1'b1}} : accSum[W-1:0]};
                accNext = res_o[W-1:0];
            end
            default: res_o = '0;
        endcase
        acc_d = load_i ? accNext : acc_q;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/alu_array_pipe.sv
// NCH-channel ALU array behind a 2-stage valid/ready pipeline with sticky per-channel overflow.
module alu_array_pipe
    import alu_array_pkg::*;
#(
    parameter int NCH = 2,
    parameter int W   = 4,
    parameter bit SAT = 1'b0
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*W-1:0]     a,
    input  logic [NCH*W-1:0]     b,
    input  logic [NCH*OPW-1:0]   op,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*(W+1)-1:0] result,
    output logic [NCH-1:0]       zero,
    output logic [NCH-1:0]       ovf,
    input  logic                 ovf_clr
);

    logic                 s1Valid_q;
    logic [NCH*W-1:0]     s1A_q;
    logic [NCH*W-1:0]     s1B_q;
    logic [NCH*OPW-1:0]   s1Op_q;
    logic                 s1Clr_q;
    logic                 outValid_q;
    logic [NCH*(W+1)-1:0] result_q;
    logic [NCH-1:0]       zero_q;
    logic [NCH-1:0]       ovf_q;
    logic [NCH-1:0]       ovf_d;

    logic                 en1;
    logic                 en2;
    logic                 accept;
    logic                 xfer;
    logic [NCH*(W+1)-1:0] laneRes;
    logic [NCH-1:0]       laneCarry;
    logic [NCH-1:0]       laneZero;

    assign en2      = !outValid_q || out_ready;
    assign en1      = !s1Valid_q || en2;
    assign accept   = in_valid && en1;
    assign xfer     = s1Valid_q && en2;
    assign in_ready = en1;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        localparam int unsigned LO_D = sliceLo(i, W);
        localparam int unsigned LO_O = sliceLo(i, OPW);
        localparam int unsigned LO_R = sliceLo(i, W + 1);

        alu_lane #(.W(W), .SAT(SAT)) u_lane (
            .clock_i  (clock),
            .resetb_i (resetb),
            .a_i      (s1A_q[LO_D +: W]),
            .b_i      (s1B_q[LO_D +: W]),
            .op_i     (s1Op_q[LO_O +: OPW]),
            .accClr_i (s1Clr_q),
            .load_i   (xfer),
            .res_o    (laneRes[LO_R +: W+1]),
            .carry_o  (laneCarry[i])
        );

        assign laneZero[i] = (laneRes[LO_R +: W] == '0);
    end

    // A flag-setting event outranks a coincident clear so no overflow is ever missed.
    always_comb begin
        ovf_d = (ovf_q & ~{NCH{ovf_clr}}) | (laneCarry & {NCH{xfer}});
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            s1Valid_q  <= 1'b0;
            s1A_q      <= '0;
            s1B_q      <= '0;
            s1Op_q     <= '0;
            s1Clr_q    <= 1'b0;
            outValid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= '0;
            ovf_q      <= '0;
        end else begin
            if (en1) begin
                s1Valid_q <= in_valid;
            end
            if (accept) begin
                s1A_q   <= a;
                s1B_q   <= b;
                s1Op_q  <= op;
                s1Clr_q <= acc_clr;
            end
            if (en2) begin
                outValid_q <= s1Valid_q;
            end
            if (xfer) begin
                result_q <= laneRes;
                zero_q   <= laneZero;
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = outValid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/alu_array_pipe.md
Name: alu_array_pipe

Overview:
Parametrised multi-channel ALU array for the user-project area. It generalises the fixed dual 4-bit, 2-bit-select ALU macro to NCH independent channels of W-bit operands. It adds a 3-bit opcode set, optional saturation, per-channel accumulators and sticky overflow flags. Operands enter through a valid/ready handshake and pass through a 2-stage pipeline with full backpressure. Outputs drive mprj_io or a Wishbone shim.

Parameters:
NCH, 2, number of independent ALU channels (1..8)
W, 4, operand width per channel (2..16)
SAT, 0, 1 = ADD/SUB/ACC saturate instead of wrapping

Ports:
clock  input  1  system clock
resetb  input  1  asynchronous active-low reset
in_valid  input  1  operand bundle valid
in_ready  output  1  array can accept a bundle this cycle
a  input  NCH*W  operand A, channel i at [i*W +: W]
b  input  NCH*W  operand B, channel i at [i*W +: W]
op  input  NCH*3  opcode, channel i at [i*3 +: 3]
acc_clr  input  1  clear all accumulators (qualified by in_valid && in_ready)
out_valid  output  1  result bundle valid
out_ready  input  1  downstream accepts result
result  output  NCH*(W+1)  channel i at [i*(W+1) +: W+1]; bit W is carry/borrow
zero  output  NCH  registered; result[W-1:0]==0 per channel
ovf  output  NCH  sticky overflow per channel
ovf_clr  input  1  synchronous clear of all ovf bits

Behaviour:
- Reset (resetb low, async): all pipeline valids 0, in_ready 1, out_valid 0, result 0, zero 0, ovf 0, accumulators 0.
- Opcodes: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 XOR; 101 NOT a; 110 SHL a<<1 (bit W = shifted-out MSB); 111 ACC acc=acc+a, result=new acc.
- Width rules: ADD/ACC carry = bit W of the (W+1)-bit sum. SUB borrow = (a<b). Logic ops report bit W = 0.
- SAT=1: ADD/ACC overflow clamps to 2^W-1. SUB underflow clamps to 0. Bit W still reports raw carry/borrow. The accumulator holds the clamped value.
- Pipeline: S1 registers a/b/op/acc_clr. S2 computes and registers result/zero. Latency 2 cycles from accept to out_valid.
- Enables: en2 = !out_valid || out_ready. en1 = !s1_valid || en2. in_ready = en1 (combinational from out_ready).
- Handshakes: accept when in_valid && in_ready. Result consumed when out_valid && out_ready. A stalled result is held stable. Full throughput is 1 bundle/cycle.
- Accumulator: updates only when the S1->S2 transfer occurs with op=ACC. acc_clr applies in the same transfer. If acc_clr and ACC coincide, acc = a. If acc_clr accompanies a non-ACC op, acc = 0.
- ovf[i]: sets on carry/borrow from ADD, SUB or ACC at the S2 load. If ovf_clr and a set event coincide, set wins. ovf is not cleared by consuming the result.
- Channels are independent. Mixed opcodes within one bundle are legal.
- Reset mid-operation: in-flight bundles are discarded. No partial output appears after reset is released.

Decomposition:
- Package alu_array_pkg: opcode localparams (OP_ADD..OP_ACC), opcode width 3, slice-index helper functions.
- One sub-module alu_lane: a single channel with combinational op decode, saturation, carry and the accumulator register, instantiated NCH times by generate.
- The top level holds the handshake, pipeline valids and flag registers.

Test Plan:
- W=4, SAT=0, ch0 ADD a=9 b=9 -> 2 cycles after accept: result ch0 = 5'b10010, ovf[0]=1, zero[0]=0.
- Same stimulus with SAT=1 -> result ch0 = 5'b11111 (clamped 15, carry 1). SUB a=3 b=5 -> 5'b10000 with SAT=1; 5'b11110 with SAT=0.
- ch1 ACC with a=7 repeated 3 times, first with acc_clr=1 -> results 7, 14, 21 mod 16 = 5 with carry 1, ovf[1]=1. Then acc_clr with ACC a=2 -> 2.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2 accepts. result stays stable. On release all bundles arrive in order with none lost or duplicated.
- Assert resetb low with 2 bundles in flight -> out_valid=0, ovf=0, accumulators 0. The first post-reset bundle appears after exactly 2 cycles.
- ovf_clr coincident with a new ADD overflow -> ovf stays 1. ovf_clr alone on the next cycle -> ovf=0.
